// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: table code bits then coefficient magnitude bits,
// MSB first, on a one-bit valid/ready stream.
module huffman_encoder #(
  parameter int NUM_ENTRIES  = 53,
  parameter int MAX_CODE_LEN = 16
) (
  input  logic        phi1,
  input  logic        reset_s1,
  input  logic        tbl_we_s1,
  input  logic [5:0]  tbl_addr_s1,
  input  logic [15:0] tbl_code_s1,
  input  logic [4:0]  tbl_len_s1,
  input  logic        sym_valid_s1,
  output logic        sym_ready_s1,
  input  logic [5:0]  sym_index_s1,
  input  logic [14:0] sym_coeff_s1,
  input  logic [3:0]  sym_size_s1,
  output logic        bit_out_s1,
  output logic        bit_valid_s1,
  input  logic        bit_ready_s1,
  output logic        err_s1,
  output logic        busy_s1
);

  localparam logic [5:0] LP_NENT = 6'(NUM_ENTRIES);
  localparam logic [4:0] LP_MAXL = 5'(MAX_CODE_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CODE,
    S_COEFF
  } state_t;

  logic [4:0]  r_len_tab  [0:NUM_ENTRIES-1];
  logic [15:0] r_code_tab [0:NUM_ENTRIES-1];

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_code;
  logic [14:0] r_coeff;
  logic [3:0]  r_size;
  logic        r_out;
  logic        r_valid;
  logic        r_ready;
  logic        r_err;
  logic        r_busy;

  logic        w_tbl_wr;
  logic        w_idx_ok;
  logic [4:0]  w_len;
  logic [15:0] w_lcode;
  logic        w_bad;
  logic [3:0]  w_len_m1;
  logic        w_accept;
  logic [3:0]  w_cnt_m1;
  logic [3:0]  w_size_m1;

  assign w_tbl_wr = tbl_we_s1 &&
                    (tbl_addr_s1 < LP_NENT);
  assign w_idx_ok = sym_index_s1 < LP_NENT;

  // Lookup reads the pre-edge table, so a same-edge write is not seen.
  assign w_len   = w_idx_ok ?
                   r_len_tab[sym_index_s1] : 5'd0;
  assign w_lcode = w_idx_ok ?
                   r_code_tab[sym_index_s1] : 16'd0;

  assign w_bad = !w_idx_ok ||
                 (w_len == 5'd0) ||
                 (w_len > LP_MAXL);

  // len 16 wraps to 0 in four bits, giving 15 as expected.
  assign w_len_m1  = w_len[3:0] - 4'd1;
  assign w_cnt_m1  = r_cnt - 4'd1;
  assign w_size_m1 = r_size - 4'd1;

  assign sym_ready_s1 = r_ready && !reset_s1;
  assign w_accept     = sym_valid_s1 &&
                        sym_ready_s1;

  assign bit_out_s1   = r_out;
  assign bit_valid_s1 = r_valid;
  assign err_s1       = r_err;
  assign busy_s1      = r_busy;

  always_ff @(posedge phi1) begin
    if (reset_s1) begin
      for (int i = 0; i < NUM_ENTRIES; i++)
        r_len_tab[i] <= 5'd0;
    end else if (w_tbl_wr) begin
      r_len_tab[tbl_addr_s1] <= tbl_len_s1;
    end
  end

  always_ff @(posedge phi1) begin
    if (w_tbl_wr)
      r_code_tab[tbl_addr_s1] <= tbl_code_s1;
  end

  always_ff @(posedge phi1) begin
    if (w_accept) begin
      r_code  <= w_lcode;
      r_coeff <= sym_coeff_s1;
      r_size  <= sym_size_s1;
    end
  end

  always_ff @(posedge phi1) begin
    if (reset_s1) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_state <= S_CODE;
              r_cnt   <= w_len_m1;
              r_out   <= w_lcode[w_len_m1];
              r_valid <= 1'b1;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end
        S_CODE: begin
          if (bit_ready_s1) begin
            if (r_cnt != 4'd0) begin
              r_cnt <= w_cnt_m1;
              r_out <= r_code[w_cnt_m1];
            end else if (r_size != 4'd0) begin
              r_state <= S_COEFF;
              r_cnt   <= w_size_m1;
              r_out   <= r_coeff[w_size_m1];
            end else begin
              r_state <= S_IDLE;
              r_out   <= 1'b0;
              r_valid <= 1'b0;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_COEFF: begin
          if (bit_ready_s1) begin
            if (r_cnt != 4'd0) begin
              r_cnt <= w_cnt_m1;
              r_out <= r_coeff[w_cnt_m1];
            end else begin
              r_state <= S_IDLE;
              r_out   <= 1'b0;
              r_valid <= 1'b0;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_out   <= 1'b0;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/huffman_encoder.md
# huffman_encoder

Serial Huffman encoder for 4x4 coefficient blocks; it is the transmit-side counterpart of the decoder's lookup-table datapath. It accepts one (table index, coefficient) symbol at a time and emits the variable-length Huffman code for that index followed by the coefficient's `coeff_size` magnitude bits, MSB first, on a one-bit ready/valid stream. Its 53-entry code table is programmed at initialization through a write port that mirrors the decoder's table-2 load port. It therefore produces exactly the bitstream the decoder consumes.

## Interface
- `NUM_ENTRIES`, 53: number of valid table entries (addresses 0..52).
- `MAX_CODE_LEN`, 16: maximum Huffman code length in bits.
- `phi1` input 1: the single clock; all state updates on its rising edge.
- `reset_s1` input 1: synchronous, active-high reset.
- `tbl_we_s1` input 1: table write enable.
- `tbl_addr_s1` input 6: table write address.
- `tbl_code_s1` input 16: code bits, right-justified (LSB-aligned).
- `tbl_len_s1` input 5: code length, 0..16; 0 marks the entry invalid.
- `sym_valid_s1` input 1: symbol offered.
- `sym_ready_s1` output 1: encoder can accept a symbol.
- `sym_index_s1` input 6: table index, built as {run_length[1:0], coeff_size[3:0]}.
- `sym_coeff_s1` input 15: coefficient bits, right-justified.
- `sym_size_s1` input 4: coefficient size, 0..15.
- `bit_out_s1` output 1: serial data bit.
- `bit_valid_s1` output 1: `bit_out_s1` is valid.
- `bit_ready_s1` input 1: downstream accepts the bit.
- `err_s1` output 1: one-cycle pulse on an invalid symbol.
- `busy_s1` output 1: high while not IDLE.

## Operation
- Table storage is `len[0:52]` (5 bits) and `code[0:52]` (16 bits).
  - Reset clears every `len` to 0; `code` contents are don't-care.
  - A write with `tbl_we_s1=1` and `tbl_addr_s1<53` updates both arrays at the clock edge.
  - Writes to addresses 53..63 are ignored.
  - Writes are legal in any state. A symbol already accepted keeps its latched code.
- The FSM has three states: IDLE, CODE, COEFF.
  - **IDLE:** `sym_ready_s1=1`. On `sym_valid_s1 && sym_ready_s1`, latch `code[idx]`, `len[idx]`, coeff and size.
    - If `sym_index_s1>=53`, or the looked-up `len` is 0, or `len>16`: pulse `err_s1` next cycle, consume the symbol, stay in IDLE.
    - Otherwise load `bit_cnt = len-1` and go to CODE.
  - **CODE:** `bit_out_s1 = code_latched[bit_cnt]`, `bit_valid_s1=1`. On `bit_ready_s1`:
    - if `bit_cnt==0`, go to COEFF when size>0, else to IDLE;
    - otherwise decrement `bit_cnt`.
  - **COEFF:** `bit_cnt` is loaded with size-1 on entry. `bit_out_s1 = coeff_latched[bit_cnt]`, `bit_valid_s1=1`. On `bit_ready_s1`, go to IDLE if `bit_cnt==0`, else decrement.
- Coefficient bits at and above position `size` are ignored.
- The table lookup samples array contents before any same-edge write. A write and an accept to the same address in the same cycle therefore encode the old entry.
- `sym_ready_s1` is low in CODE and COEFF. Upstream must hold its symbol until the handshake completes.

## Timing
- Reset values: `sym_ready_s1=0` during the reset cycle and 1 from the first cycle after; `bit_valid_s1=0`, `bit_out_s1=0`, `err_s1=0`, `busy_s1=0`; FSM in IDLE; all `len` = 0.
- Reset asserted mid-symbol aborts it immediately. No further bits are emitted, and the table is cleared.
- Latency: the first code bit is valid on the cycle after the accept edge.
- `bit_out_s1` is stable while `bit_valid_s1 && !bit_ready_s1`. There is no combinational path from `bit_ready_s1` to `bit_valid_s1`.
- Throughput with `bit_ready_s1` held at 1: `len + size` bit cycles, plus 1 IDLE cycle, per symbol.
- `err_s1` is high for exactly one cycle, the cycle after the accept. `sym_ready_s1` stays 1 through that cycle.

## Test plan
- **Reset then write and encode:** reset, then write addr 5 = code 0b101, len 3. Send idx 5, size 2, coeff 0b10 with `bit_ready_s1`=1 → bits 1,0,1,1,0 on 5 consecutive cycles starting 1 cycle after accept; `sym_ready_s1` returns 1 on the next cycle.
- **Backpressure:** same symbol with `bit_ready_s1` toggling 1,0,0,1,... → each bit held stable while not ready; the same 5-bit sequence results; no bit dropped or duplicated.
- **Size 0 and max length:** addr 52 = 0xFFFF, len 16, size 0 → exactly 16 ones, then IDLE; COEFF never entered.
- **Invalid entries:** unwritten idx 7 → `err_s1` pulse, no `bit_valid_s1`. idx 60 → `err_s1` pulse. Write to addr 55 → no change to entries 0..52.
- **Same-edge write and accept:** addr 3 holds 0b11/len 2. Write 0b0/len 1 in the same cycle as accepting idx 3 → emits 1,1. The next idx-3 symbol emits 0.
- **Reset mid-operation:** assert `reset_s1` during CODE bit 2 of 3 → `bit_valid_s1=0` the next cycle. A following idx-5 symbol gives `err_s1` because the table was cleared.
